// File: rtl/tm_master_reply_reorder.sv
// tm_master_reply_reorder: restores issue order for replies coming back on
// several return VCs. Each issued request records its return VC in an order
// log. Replies are parked in per-VC FIFOs. The registered output stage only
// pulls from the VC named at the log head, so the output follows issue order.

// Per-VC reply FIFO. The caller never pushes while full and never pops while empty.
module tm_mrr_vc_buf #(
   parameter int WIDTH_DATA = 36,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [WIDTH_DATA-1:0] data_i,
   input  logic                  pop_i,
   output logic [WIDTH_DATA-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   logic [WIDTH_DATA-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;

   assign data_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == FULL_C);
   assign empty_o = (cnt_q == '0);

   // Storage needs no reset; pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i)  rd_q <= rd_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

module tm_master_reply_reorder #(
   parameter  int WIDTH_DATA       = 36,
   parameter  int VC_ADDRESS_WIDTH = 2,
   parameter  int ORDER_DEPTH      = 32,
   parameter  int VC_BUF_DEPTH     = 4,
   localparam int NUM_VC           = 2**VC_ADDRESS_WIDTH,
   localparam int CNT_W            = $clog2(ORDER_DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   input  logic [VC_ADDRESS_WIDTH-1:0]  issue_ret_vc,
   output logic                         issue_ready,
   input  logic [NUM_VC-1:0]            rx_valid,
   input  logic [NUM_VC*WIDTH_DATA-1:0] rx_data,
   output logic [NUM_VC-1:0]            rx_ready,
   output logic                         out_valid,
   output logic [WIDTH_DATA-1:0]        out_data,
   output logic [VC_ADDRESS_WIDTH-1:0]  out_ret_vc,
   input  logic                         out_ready,
   output logic [CNT_W-1:0]             outstanding,
   output logic                         err_unexpected
);
   localparam int LAW = $clog2(ORDER_DEPTH);
   localparam logic [CNT_W-1:0] OD_C = CNT_W'(ORDER_DEPTH);

   logic [VC_ADDRESS_WIDTH-1:0] log_mem_q [ORDER_DEPTH];
   logic [LAW-1:0]              log_wr_q, log_rd_q;
   logic [CNT_W-1:0]            log_cnt_q;
   logic [NUM_VC-1:0][CNT_W-1:0] pend_q;

   logic [NUM_VC-1:0][WIDTH_DATA-1:0] buf_data;
   logic [NUM_VC-1:0] buf_full, buf_empty, acc, drop, pop;
   logic [VC_ADDRESS_WIDTH-1:0] head_vc;
   logic push_iss, load;

   logic                        out_valid_q;
   logic [WIDTH_DATA-1:0]       out_data_q;
   logic [VC_ADDRESS_WIDTH-1:0] out_vc_q;
   logic                        err_q;

   assign issue_ready    = (log_cnt_q < OD_C);
   assign push_iss       = issue_valid & issue_ready;
   assign head_vc        = log_mem_q[log_rd_q];
   // Load only when the head VC's reply is already parked; no bypass from rx.
   assign load           = (~out_valid_q | out_ready) & (log_cnt_q != '0) & ~buf_empty[head_vc];
   assign rx_ready       = ~buf_full;
   assign outstanding    = log_cnt_q;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_ret_vc     = out_vc_q;
   assign err_unexpected = err_q;

   for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
      // A reply is only kept if its VC still owes one; otherwise it is dropped.
      assign acc[g]  = rx_valid[g] & ~buf_full[g] & (pend_q[g] != '0);
      assign drop[g] = rx_valid[g] & ~buf_full[g] & (pend_q[g] == '0);
      assign pop[g]  = load & (head_vc == VC_ADDRESS_WIDTH'(g));

      tm_mrr_vc_buf #(.WIDTH_DATA(WIDTH_DATA), .DEPTH(VC_BUF_DEPTH)) u_buf (
         .clk    (clk),
         .rst    (rst),
         .push_i (acc[g]),
         .data_i (rx_data[g*WIDTH_DATA +: WIDTH_DATA]),
         .pop_i  (pop[g]),
         .data_o (buf_data[g]),
         .full_o (buf_full[g]),
         .empty_o(buf_empty[g])
      );
   end

   // Order log storage: return VC of each accepted issue.
   always_ff @(posedge clk) begin
      if (push_iss) log_mem_q[log_wr_q] <= issue_ret_vc;
   end

   // Order log pointers; the count drops on output load, not on consumption.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         log_wr_q  <= '0;
         log_rd_q  <= '0;
         log_cnt_q <= '0;
      end else begin
         if (push_iss) log_wr_q <= log_wr_q + LAW'(1);
         if (load)     log_rd_q <= log_rd_q + LAW'(1);
         case ({push_iss, load})
            2'b10:   log_cnt_q <= log_cnt_q + CNT_W'(1);
            2'b01:   log_cnt_q <= log_cnt_q - CNT_W'(1);
            default: log_cnt_q <= log_cnt_q;
         endcase
      end
   end

   // Per-VC replies still owed: issues pushed minus replies accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
      end else begin
         for (int i = 0; i < NUM_VC; i++) begin
            case ({push_iss && (issue_ret_vc == VC_ADDRESS_WIDTH'(i)), acc[i]})
               2'b10:   pend_q[i] <= pend_q[i] + CNT_W'(1);
               2'b01:   pend_q[i] <= pend_q[i] - CNT_W'(1);
               default: pend_q[i] <= pend_q[i];
            endcase
         end
      end
   end

   // Registered output stage; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_vc_q    <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         out_data_q  <= buf_data[head_vc];
         out_vc_q    <= head_vc;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Sticky flag for replies nobody asked for.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else if (|drop) err_q <= 1'b1;
   end
endmodule

// File: tb/tb_tm_master_reply_reorder.sv
// Bench for tm_master_reply_reorder: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_tm_master_reply_reorder;
   localparam int W  = 36;
   localparam int NV = 4;
   localparam int OD = 32;
   localparam int BD = 4;
   localparam int CW = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue_valid;
   logic [1:0]        issue_ret_vc;
   logic              issue_ready;
   logic [NV-1:0]     rx_valid;
   logic [NV*W-1:0]   rx_data;
   logic [NV-1:0]     rx_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [1:0]        out_ret_vc;
   logic              out_ready;
   logic [CW-1:0]     outstanding;
   logic              err_unexpected;

   tm_master_reply_reorder dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ret_vc(issue_ret_vc), .issue_ready(issue_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ret_vc(out_ret_vc),
      .out_ready(out_ready), .outstanding(outstanding), .err_unexpected(err_unexpected)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: issue-order queue, per-VC reply queues, output register.
   int           ord[$];
   logic [W-1:0] bq[NV][$];
   bit           m_ov;
   logic [W-1:0] m_data;
   int           m_vc;
   bit           m_err;

   function automatic int pend(int v);
      int c = 0;
      foreach (ord[k]) if (ord[k] == v) c++;
      return c - bq[v].size();
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      ord.delete();
      for (int i = 0; i < NV; i++) bq[i].delete();
      m_ov = 0; m_data = '0; m_vc = 0; m_err = 0;
   endtask

   task automatic model_edge(bit iv, logic [1:0] ivc, logic [NV-1:0] rxv,
                             logic [NV*W-1:0] rxd, bit ordy);
      bit acc[NV];
      bit ir, ld;
      int h;
      ir = ord.size() < OD;
      for (int i = 0; i < NV; i++) begin
         acc[i] = 0;
         if (rxv[i] && bq[i].size() < BD) begin
            if (pend(i) > 0) acc[i] = 1;
            else m_err = 1;
         end
      end
      ld = (!m_ov || ordy) && ord.size() > 0 && bq[ord[0]].size() > 0;
      if (ld) begin
         h = ord.pop_front();
         m_data = bq[h].pop_front();
         m_vc = h;
         m_ov = 1;
      end else if (ordy) m_ov = 0;
      for (int i = 0; i < NV; i++) if (acc[i]) bq[i].push_back(rxd[i*W +: W]);
      if (iv && ir) ord.push_back(int'(ivc));
   endtask

   task automatic check_all();
      logic [NV-1:0] er;
      for (int i = 0; i < NV; i++) er[i] = (bq[i].size() < BD);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_data", out_data, m_data);
         chk("out_ret_vc", out_ret_vc, m_vc);
      end
      chk("outstanding", outstanding, ord.size());
      chk("issue_ready", issue_ready, ord.size() < OD);
      chk("rx_ready", rx_ready, er);
      chk("err_unexpected", err_unexpected, m_err);
   endtask

   // Called just after a falling edge: drive, model the rising edge, check.
   task automatic step(bit iv, logic [1:0] ivc, logic [NV-1:0] rxv,
                       logic [NV*W-1:0] rxd, bit ordy);
      issue_valid = iv; issue_ret_vc = ivc; rx_valid = rxv; rx_data = rxd; out_ready = ordy;
      @(posedge clk);
      model_edge(iv, ivc, rxv, rxd, ordy);
      @(negedge clk);
      check_all();
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_ov"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_vc"}, out_ret_vc, 0);
      chk({tag, "_outst"}, outstanding, 0);
      chk({tag, "_err"}, err_unexpected, 0);
      chk({tag, "_ir"}, issue_ready, 1);
      chk({tag, "_rxr"}, rx_ready, 4'hF);
   endtask

   task automatic do_reset();
      issue_valid = 0; issue_ret_vc = 0; rx_valid = 0; rx_data = '0; out_ready = 1;
      rst = 0;
      model_clear();
      @(negedge clk);
      #1 chk_reset_vals("rst");
      @(negedge clk);
      rst = 1;
   endtask

   function automatic logic [NV*W-1:0] rnd_data();
      logic [NV*W-1:0] r;
      for (int i = 0; i < NV; i++) r[i*W +: W] = W'({$urandom(), $urandom()});
      return r;
   endfunction

   typedef struct {
      bit           iv;
      logic [1:0]   ivc;
      logic [NV-1:0] rxv;
      bit           ordy;
      bit           e_ov;
      logic [1:0]   e_vc;
      logic [W-1:0] e_data;
      int           e_outst;
   } vec_t;

   vec_t tbl[10];
   logic [NV*W-1:0] fixd;

   initial begin
      int n3;
      logic [NV-1:0] rv;
      rst = 0;
      for (int i = 0; i < NV; i++) fixd[i*W +: W] = W'(36'hA00 + i);

      // Issue 2,0,1; replies on VC1, VC0, VC2; output follows issue order.
      tbl[0] = '{1, 2'd2, 4'b0000, 1, 0, 2'd0, 36'h0,   1};
      tbl[1] = '{1, 2'd0, 4'b0000, 1, 0, 2'd0, 36'h0,   2};
      tbl[2] = '{1, 2'd1, 4'b0000, 1, 0, 2'd0, 36'h0,   3};
      tbl[3] = '{0, 2'd0, 4'b0010, 1, 0, 2'd0, 36'h0,   3};
      tbl[4] = '{0, 2'd0, 4'b0001, 1, 0, 2'd0, 36'h0,   3};
      tbl[5] = '{0, 2'd0, 4'b0100, 1, 0, 2'd0, 36'h0,   3};
      tbl[6] = '{0, 2'd0, 4'b0000, 1, 1, 2'd2, 36'hA02, 2};
      tbl[7] = '{0, 2'd0, 4'b0000, 1, 1, 2'd0, 36'hA00, 1};
      tbl[8] = '{0, 2'd0, 4'b0000, 1, 1, 2'd1, 36'hA01, 0};
      tbl[9] = '{0, 2'd0, 4'b0000, 1, 0, 2'd0, 36'h0,   0};

      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(tbl[k].iv, tbl[k].ivc, tbl[k].rxv, fixd, tbl[k].ordy);
         chk($sformatf("tbl%0d_ov", k), out_valid, tbl[k].e_ov);
         if (tbl[k].e_ov) begin
            chk($sformatf("tbl%0d_vc", k), out_ret_vc, tbl[k].e_vc);
            chk($sformatf("tbl%0d_data", k), out_data, tbl[k].e_data);
         end
         chk($sformatf("tbl%0d_outst", k), outstanding, tbl[k].e_outst);
      end

      // Fill the order log; the 33rd issue is ignored; one load frees a slot.
      do_reset();
      for (int k = 0; k < 32; k++) step(1, 2'd0, 4'b0, fixd, 1);
      chk("full_outst", outstanding, 32);
      chk("full_ir", issue_ready, 0);
      step(1, 2'd0, 4'b0, fixd, 1);
      chk("full33_outst", outstanding, 32);
      step(0, 2'd0, 4'b0001, fixd, 1);
      chk("full_acc_outst", outstanding, 32);
      step(0, 2'd0, 4'b0000, fixd, 1);
      chk("full_load_outst", outstanding, 31);
      chk("full_load_ir", issue_ready, 1);

      // Head blocked on VC0 while VC3 replies fill its buffer.
      do_reset();
      step(1, 2'd0, 4'b0, fixd, 0);
      for (int k = 0; k < 5; k++) step(1, 2'd3, 4'b0, fixd, 0);
      for (int k = 0; k < 4; k++) step(0, 2'd0, 4'b1000, rnd_data(), 0);
      chk("vc3_full_rxr", rx_ready[3], 0);
      step(0, 2'd0, 4'b1000, rnd_data(), 0);
      chk("vc3_still_full", rx_ready[3], 0);
      step(0, 2'd0, 4'b0001, rnd_data(), 0);
      n3 = 0;
      for (int k = 0; k < 12; k++) begin
         rv = (pend(3) > 0) ? 4'b1000 : 4'b0000;
         step(0, 2'd0, rv, rnd_data(), 1);
         if (out_valid && out_ret_vc == 2'd3) n3++;
      end
      chk("vc3_count", n3, 5);
      chk("vc3_drain_outst", outstanding, 0);

      // Unexpected reply sets the sticky error; later traffic is unaffected.
      do_reset();
      step(0, 2'd0, 4'b0010, fixd, 1);
      chk("err_set", err_unexpected, 1);
      step(1, 2'd1, 4'b0000, fixd, 1);
      step(0, 2'd0, 4'b0010, fixd, 1);
      step(0, 2'd0, 4'b0000, fixd, 1);
      chk("err_ov", out_valid, 1);
      chk("err_data", out_data, 36'hA01);
      chk("err_sticky", err_unexpected, 1);

      // Output stall for 3 cycles, then back-to-back drain.
      do_reset();
      step(1, 2'd0, 4'b0, fixd, 0);
      step(1, 2'd1, 4'b0, fixd, 0);
      step(1, 2'd2, 4'b0, fixd, 0);
      step(0, 2'd0, 4'b0111, fixd, 0);
      step(0, 2'd0, 4'b0000, fixd, 0);
      for (int k = 0; k < 3; k++) begin
         step(0, 2'd0, 4'b0000, fixd, 0);
         chk($sformatf("stall%0d_data", k), out_data, 36'hA00);
         chk($sformatf("stall%0d_vc", k), out_ret_vc, 0);
      end
      step(0, 2'd0, 4'b0000, fixd, 1);
      chk("b2b1_vc", out_ret_vc, 1);
      step(0, 2'd0, 4'b0000, fixd, 1);
      chk("b2b2_vc", out_ret_vc, 2);
      chk("b2b2_ov", out_valid, 1);

      // Asynchronous reset mid-operation: 3 outstanding, 2 buffered.
      do_reset();
      step(1, 2'd0, 4'b0, fixd, 1);
      step(1, 2'd1, 4'b0, fixd, 1);
      step(1, 2'd2, 4'b0, fixd, 1);
      step(0, 2'd0, 4'b0110, fixd, 1);
      chk("pre_arst_outst", outstanding, 3);
      issue_valid = 0; rx_valid = 0;
      #2 rst = 0;
      #1 chk_reset_vals("arst");
      model_clear();
      @(negedge clk);
      chk_reset_vals("arst_hold");
      rst = 1;
      step(0, 2'd0, 4'b0000, fixd, 1);
      chk("post_arst_ov", out_valid, 0);

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NV; i++)
            rv[i] = (pend(i) > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
         step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), rv, rnd_data(),
              $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
